// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: datapath sizes,
// operation encodings and sequencer states.
package alu_pkg;

   localparam int WIDTH     = 16;
   localparam int NREG_BITS = 3;

   typedef logic [0:WIDTH-1]     word_t;
   typedef logic [0:NREG_BITS-1] reg_addr_t;
   typedef logic [0:2]           op_t;

   // Bit 0 is the MSB on every vector in this design.
   localparam op_t OP_ADD  = 3'b000;
   localparam op_t OP_SUB  = 3'b001;
   localparam op_t OP_AND  = 3'b010;
   localparam op_t OP_OR   = 3'b011;
   localparam op_t OP_XOR  = 3'b100;
   localparam op_t OP_NOT  = 3'b101;
   localparam op_t OP_SHL  = 3'b110;
   localparam op_t OP_PASS = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction channel, register-file ports and status of the ALU sequencer.
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; the source holds op/rd/rs1/rs2 stable until then.
interface alu_seq_if;
   import alu_pkg::*;

   logic      instr_valid;
   logic      instr_ready;
   op_t       op;
   reg_addr_t rd;
   reg_addr_t rs1;
   reg_addr_t rs2;

   reg_addr_t rd_addr_a;
   reg_addr_t rd_addr_b;
   word_t     d_out_a;
   word_t     d_out_b;

   logic      wr;
   reg_addr_t wr_addr;
   word_t     d_in;

   logic      done;
   logic      flag_z;
   logic      flag_c;
   logic      flag_n;

   modport slave (
      input  instr_valid, op, rd, rs1, rs2, d_out_a, d_out_b,
      output instr_ready, rd_addr_a, rd_addr_b, wr, wr_addr, d_in,
             done, flag_z, flag_c, flag_n
   );

   modport master (
      output instr_valid, op, rd, rs1, rs2, d_out_a, d_out_b,
      input  instr_ready, rd_addr_a, rd_addr_b, wr, wr_addr, d_in,
             done, flag_z, flag_c, flag_n
   );

endinterface

// File: rtl/alu_seq_alu.sv
// Combinational 16-bit ALU: result plus zero, carry and negative flags.
module alu_16
   import alu_pkg::*;
(
   input  word_t a_i,
   input  word_t b_i,
   input  op_t   op_i,
   output word_t result_o,
   output logic  z_o,
   output logic  c_o,
   output logic  n_o
);

   logic [0:WIDTH] sum;

   always_comb begin
      sum      = '0;
      result_o = '0;
      c_o      = 1'b0;
      unique case (op_i)
         OP_ADD: begin
            sum      = {1'b0, a_i} + {1'b0, b_i};
            result_o = sum[1:WIDTH];
            c_o      = sum[0];
         end
         // Carry out of A + ~B + 1 is set exactly when A >= B unsigned.
         OP_SUB: begin
            sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
            result_o = sum[1:WIDTH];
            c_o      = sum[0];
         end
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_NOT:  result_o = ~a_i;
         OP_SHL: begin
            result_o = a_i << 1;
            c_o      = a_i[0];
         end
         OP_PASS: result_o = b_i;
         default: result_o = '0;
      endcase
      z_o = (result_o == '0);
      n_o = result_o[0];
   end

endmodule

// File: rtl/alu_seq.sv
// Execute/write-back sequencer around the 8x16 register file: read both
// sources, execute, then commit the result through the write port.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NREG_BITS = 3
) (
   input  logic     clk,
   input  logic     reset,
   alu_seq_if.slave bus,
   output state_t   state_o
);

   state_t state_q, state_d;

   logic [0:2]           op_q;
   logic [0:NREG_BITS-1] rd_q, rs1_q, rs2_q, wr_addr_q;
   logic [0:WIDTH-1]     a_q, b_q, result_q;
   logic                 flag_z_q, flag_c_q, flag_n_q;

   logic [0:WIDTH-1]     alu_result;
   logic                 alu_z, alu_c, alu_n;
   logic                 accept;

   alu_16 u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (alu_result),
      .z_o      (alu_z),
      .c_o      (alu_c),
      .n_o      (alu_n)
   );

   assign accept = (state_q == S_IDLE) && bus.instr_valid;

   // instr_ready is gated by reset so it reads 0 while reset is held.
   always_comb begin
      state_d         = state_q;
      bus.instr_ready = 1'b0;
      bus.wr          = 1'b0;
      bus.done        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            bus.instr_ready = !reset;
            if (bus.instr_valid) state_d = S_READ;
         end
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WRITE;
         S_WRITE: begin
            bus.wr   = 1'b1;
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // wr_addr gets its own register so it only moves on entry to WRITE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         wr_addr_q <= '0;
         flag_z_q  <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_n_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= bus.op;
            rd_q  <= bus.rd;
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
         end
         if (state_q == S_READ) begin
            a_q <= bus.d_out_a;
            b_q <= bus.d_out_b;
         end
         if (state_q == S_EXEC) begin
            result_q  <= alu_result;
            wr_addr_q <= rd_q;
            flag_z_q  <= alu_z;
            flag_c_q  <= alu_c;
            flag_n_q  <= alu_n;
         end
      end
   end

   assign bus.rd_addr_a = rs1_q;
   assign bus.rd_addr_b = rs2_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.d_in      = result_q;
   assign bus.flag_z    = flag_z_q;
   assign bus.flag_c    = flag_c_q;
   assign bus.flag_n    = flag_n_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural 8x16 register file on its own reset.
module tb_alu_seq;
   import alu_pkg::*;

   logic   clk = 1'b0;
   logic   reset;
   logic   rf_reset;
   state_t state_dbg;

   alu_seq_if bus ();

   alu_seq dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .state_o (state_dbg)
   );

   always #5 clk = ~clk;

   // Register file with a bench-side host write port used for preloads.
   word_t     rf [0:7];
   logic      host_wr;
   reg_addr_t host_addr;
   word_t     host_data;

   always @(posedge clk or posedge rf_reset) begin
      if (rf_reset) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (bus.wr) begin
         rf[bus.wr_addr] <= bus.d_in;
      end else if (host_wr) begin
         rf[host_addr] <= host_data;
      end
   end

   assign bus.d_out_a = rf[bus.rd_addr_a];
   assign bus.d_out_b = rf[bus.rd_addr_b];

   int n_tests = 0;
   int n_fail  = 0;
   int cur_vec = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, cur_vec, act, exp);
      end
   endtask

   task automatic host_write(input reg_addr_t addr, input word_t data);
      host_wr   = 1'b1;
      host_addr = addr;
      host_data = data;
      @(posedge clk);
      @(negedge clk);
      host_wr   = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic present(input op_t op, input reg_addr_t rd, input reg_addr_t rs1, input reg_addr_t rs2);
      bus.instr_valid = 1'b1;
      bus.op          = op;
      bus.rd          = rd;
      bus.rs1         = rs1;
      bus.rs2         = rs2;
   endtask

   // Issue one instruction and check every stage of its 4-cycle journey.
   task automatic run_instr(input op_t op, input reg_addr_t rd, input reg_addr_t rs1,
                            input reg_addr_t rs2, input word_t exp_res, input logic [2:0] exp_zcn);
      int k;
      wait_ready();
      present(op, rd, rs1, rs2);
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("ready_low_in_read", bus.instr_ready, 32'd0);
      check("rd_addr_a", bus.rd_addr_a, rs1);
      check("rd_addr_b", bus.rd_addr_b, rs2);
      k = 1;
      while (!bus.done && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("done_latency", k, 32'd3);
      check("wr_in_write", bus.wr, 32'd1);
      check("wr_addr", bus.wr_addr, rd);
      check("d_in", bus.d_in, exp_res);
      check("flags_zcn", {bus.flag_z, bus.flag_c, bus.flag_n}, exp_zcn);
      @(negedge clk);
      check("done_pulse_end", bus.done, 32'd0);
      check("wr_dropped", bus.wr, 32'd0);
      check("ready_after_write", bus.instr_ready, 32'd1);
      check("rf_result", rf[rd], exp_res);
      check("flags_hold", {bus.flag_z, bus.flag_c, bus.flag_n}, exp_zcn);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr"}, bus.wr, 32'd0);
      check({tag, "_done"}, bus.done, 32'd0);
      check({tag, "_d_in"}, bus.d_in, 32'd0);
      check({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
      check({tag, "_rd_addr_a"}, bus.rd_addr_a, 32'd0);
      check({tag, "_rd_addr_b"}, bus.rd_addr_b, 32'd0);
      check({tag, "_flags"}, {bus.flag_z, bus.flag_c, bus.flag_n}, 32'd0);
   endtask

   // Abort an ADD into R5 after k cycles in flight (0=READ, 1=EXEC, 2=WRITE).
   task automatic reset_in_state(input int k, input state_t exp_state);
      word_t old_r5;
      host_write(3'd6, 16'h1234);
      host_write(3'd7, 16'h0001);
      old_r5 = rf[5];
      wait_ready();
      present(OP_ADD, 3'd5, 3'd6, 3'd7);
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      repeat (k) @(negedge clk);
      check("abort_state", state_dbg, exp_state);
      reset = 1'b1;
      #1;
      check("abort_wr_async", bus.wr, 32'd0);
      check("abort_ready_in_reset", bus.instr_ready, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready_after", bus.instr_ready, 32'd1);
      check("abort_state_idle", state_dbg, S_IDLE);
      check_all_zero("abort");
      check("abort_r5_unchanged", rf[5], old_r5);
   endtask

   typedef struct {
      logic      pre;
      word_t     pre6;
      word_t     pre7;
      op_t       op;
      reg_addr_t rd;
      reg_addr_t rs1;
      reg_addr_t rs2;
      word_t     res;
      logic [2:0] zcn;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      vecs[0]  = '{1'b1, 16'h0003, 16'h0005, OP_PASS, 3'd1, 3'd0, 3'd6, 16'h0003, 3'b000};
      vecs[1]  = '{1'b0, 16'h0000, 16'h0000, OP_PASS, 3'd2, 3'd0, 3'd7, 16'h0005, 3'b000};
      vecs[2]  = '{1'b0, 16'h0000, 16'h0000, OP_ADD,  3'd3, 3'd1, 3'd2, 16'h0008, 3'b000};
      vecs[3]  = '{1'b0, 16'h0000, 16'h0000, OP_SUB,  3'd4, 3'd1, 3'd2, 16'hFFFE, 3'b001};
      vecs[4]  = '{1'b0, 16'h0000, 16'h0000, OP_SUB,  3'd5, 3'd2, 3'd2, 16'h0000, 3'b110};
      vecs[5]  = '{1'b1, 16'hFFFF, 16'h0001, OP_ADD,  3'd1, 3'd6, 3'd7, 16'h0000, 3'b110};
      vecs[6]  = '{1'b1, 16'h8001, 16'h0001, OP_SHL,  3'd2, 3'd6, 3'd7, 16'h0002, 3'b010};
      vecs[7]  = '{1'b1, 16'hF0F0, 16'h0FF0, OP_AND,  3'd3, 3'd6, 3'd7, 16'h00F0, 3'b000};
      vecs[8]  = '{1'b0, 16'h0000, 16'h0000, OP_OR,   3'd4, 3'd6, 3'd7, 16'hFFF0, 3'b001};
      vecs[9]  = '{1'b0, 16'h0000, 16'h0000, OP_XOR,  3'd5, 3'd6, 3'd7, 16'hFF00, 3'b001};
      vecs[10] = '{1'b0, 16'h0000, 16'h0000, OP_NOT,  3'd1, 3'd6, 3'd7, 16'h0F0F, 3'b000};
      vecs[11] = '{1'b0, 16'h0000, 16'h0000, OP_PASS, 3'd2, 3'd6, 3'd7, 16'h0FF0, 3'b000};
      vecs[12] = '{1'b0, 16'h0000, 16'h0000, OP_SHL,  3'd3, 3'd7, 3'd6, 16'h1FE0, 3'b000};
      vecs[13] = '{1'b0, 16'h0000, 16'h0000, OP_SUB,  3'd4, 3'd6, 3'd7, 16'hE100, 3'b011};
      vecs[14] = '{1'b0, 16'h0000, 16'h0000, OP_ADD,  3'd5, 3'd6, 3'd6, 16'hE1E0, 3'b011};

      reset           = 1'b1;
      rf_reset        = 1'b1;
      host_wr         = 1'b0;
      host_addr       = '0;
      host_data       = '0;
      bus.instr_valid = 1'b0;
      bus.op          = '0;
      bus.rd          = '0;
      bus.rs1         = '0;
      bus.rs2         = '0;

      #2;
      check("reset_ready_low", bus.instr_ready, 32'd0);
      check_all_zero("reset");
      @(negedge clk);
      reset    = 1'b0;
      rf_reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", bus.instr_ready, 32'd1);
      check("state_after_reset", state_dbg, S_IDLE);

      for (int i = 0; i < 15; i++) begin
         cur_vec = i;
         if (vecs[i].pre) begin
            host_write(3'd6, vecs[i].pre6);
            host_write(3'd7, vecs[i].pre7);
         end
         run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].res, vecs[i].zcn);
      end

      // Back-to-back with instr_valid held; the second reads the first's rd.
      cur_vec = 100;
      host_write(3'd6, 16'h0010);
      host_write(3'd7, 16'h0001);
      wait_ready();
      present(OP_ADD, 3'd1, 3'd6, 3'd7);
      @(posedge clk);
      @(negedge clk);
      present(OP_ADD, 3'd2, 3'd1, 3'd7);
      k = 1;
      while (!bus.instr_ready && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("b2b_accept_spacing", k, 32'd4);
      check("b2b_first_result", rf[1], 16'h0011);
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("b2b_rd_addr_a", bus.rd_addr_a, 32'd1);
      k = 1;
      while (!bus.done && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("b2b_done_latency", k, 32'd3);
      check("b2b_d_in", bus.d_in, 16'h0012);
      @(negedge clk);
      check("b2b_second_result", rf[2], 16'h0012);

      cur_vec = 200;
      reset_in_state(0, S_READ);
      cur_vec = 201;
      reset_in_state(1, S_EXEC);
      cur_vec = 202;
      reset_in_state(2, S_WRITE);

      cur_vec = 203;
      run_instr(OP_ADD, 3'd5, 3'd6, 3'd7, 16'h1235, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
